tiny_cpu_prog_loader: RTL and testbench
=======================================

TINY_CPU_PROG_LOADER -- requirements
Module: tiny_cpu_prog_loader

Interface
REQ-001 The block SHALL have parameter HDR_BYTE, default 8'hA5: frame start byte.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on ld_strobe, legal range 2..3.
REQ-003 clk  input  1  single clock for all state.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 ld_en  input  1  load mode request, synchronous to clk.
REQ-006 ld_strobe  input  1  external byte strobe, asynchronous; a rising edge means "byte valid".
REQ-007 ld_data  input  8  loader byte; stable from 1 cycle before the ld_strobe rise until ld_strobe falls.
REQ-008 fetch_addr  input  5  CPU program-counter read address.
REQ-009 fetch_data  output  8  program byte returned to the CPU fetch stage.
REQ-010 cpu_run  output  1  high when the program store holds a verified image and the CPU may run.
REQ-011 ld_busy  output  1  high while a frame is in progress.
REQ-012 ld_err  output  1  sticky error from the last frame.
REQ-013 ld_count  output  6  data bytes written in the current or last frame (0..32).

Function
REQ-014 The block SHALL hold a 32x8 program store, written only by the loader, with no reset of contents.
REQ-015 fetch_data SHALL equal store[fetch_addr] combinationally when cpu_run=1, and 8'h00 (NOP) when cpu_run=0.
REQ-016 ld_strobe SHALL pass through SYNC_STAGES flops plus one edge-detect flop; one byte event = one cycle where the synchronized value is 1 and the previous value was 0.
REQ-017 ld_data SHALL be captured in the byte-event cycle; byte-event to store-write latency SHALL be 0 additional cycles (write in the event cycle).
REQ-018 FSM states: IDLE, HDR, LEN, DATA, CHK, DONE, ERR.
REQ-019 IDLE->HDR when ld_en=1; cpu_run clears and ld_err clears on this transition.
REQ-020 HDR: byte==HDR_BYTE -> LEN; any other byte is discarded and the FSM stays in HDR.
REQ-021 LEN: byte in 1..32 -> DATA, with length latched, write pointer=0, checksum=0, ld_count=0; byte 0 or >32 -> ERR.
REQ-022 DATA: each byte is written to store[wptr]; wptr, ld_count increment; checksum ^= byte; after the byte where ld_count reaches length -> CHK.
REQ-023 CHK: byte==checksum -> DONE; otherwise -> ERR.
REQ-024 DONE: cpu_run=1, ld_busy=0, ld_err=0; return to IDLE when ld_en=0; a new ld_en rise SHALL start a new frame.
REQ-025 ERR: ld_err=1, cpu_run=0; return to IDLE when ld_en=0; ld_err SHALL stay set in IDLE until the next frame starts.
REQ-026 ld_busy SHALL be 1 in HDR, LEN, DATA and CHK, and 0 otherwise.
REQ-027 If ld_en=0 in HDR/LEN/DATA/CHK, the frame SHALL abort: go to ERR in the same cycle, with any byte event in that cycle ignored.
REQ-028 wptr is 5 bits; with length 32 the last write targets address 31 and no wrap write SHALL occur.
REQ-029 Bytes written before an error SHALL remain in the store, but cpu_run stays 0, so the CPU only sees NOPs.
REQ-030 Byte events in IDLE, DONE or ERR SHALL be ignored.

Reset
REQ-031 While reset_n=0: state=IDLE, cpu_run=0, ld_busy=0, ld_err=0, ld_count=0, synchronizer and edge flops=0, checksum=0, wptr=0.
REQ-032 Reset assertion mid-frame SHALL abort immediately; after release the block waits in IDLE for ld_en, and the store keeps its prior contents.

Verification
REQ-033 Good frame: ld_en=1, send A5,03,21,7D,A3,FF (checksum 21^7D^A3=FF) -> ld_count=3, DONE, cpu_run=1; fetch_addr 0/1/2 returns 21/7D/A3.
REQ-034 Bad checksum: send A5,02,11,22,00 -> ERR, ld_err=1, cpu_run=0, fetch_data=00 for every address.
REQ-035 Length bounds: LEN=00 -> ERR; LEN=21h -> ERR; LEN=20h with 32 bytes and correct XOR -> DONE, store[31]=last byte.
REQ-036 Header hunt: send 00,5A,A5,01,3C,3C -> the first two bytes are ignored, the frame succeeds, and store[0]=3C.
REQ-037 Abort: drop ld_en after 2 of 4 data bytes -> ERR on that cycle, ld_busy=0, ld_err=1; then reassert ld_en and send a good frame -> ld_err clears and the frame reaches DONE.
REQ-038 Strobe timing: strobe held high 10 cycles -> exactly one byte event; reset_n pulsed low in DATA -> all outputs at reset values the same cycle.

Source files
------------

// File: rtl/tiny_cpu_prog_loader.sv
// Byte-serial program loader for a 32x8 program store: hunts for a header byte,
// then takes a length, payload and XOR checksum before letting the CPU fetch from the store.
module tiny_cpu_prog_loader #(
    parameter logic [7:0] HDR_BYTE    = 8'hA5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ld_en,
    input  logic       ld_strobe,
    input  logic [7:0] ld_data,
    input  logic [4:0] fetch_addr,
    output logic [7:0] fetch_data,
    output logic       cpu_run,
    output logic       ld_busy,
    output logic       ld_err,
    output logic [5:0] ld_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_LEN, S_DATA, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   edge_q, edge_d;
    logic [5:0]             len_q, len_d;
    logic [5:0]             cnt_q, cnt_d;
    logic [4:0]             wptr_q, wptr_d;
    logic [7:0]             csum_q, csum_d;
    logic                   run_q, run_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;
    logic                   byte_ev;
    logic                   we;
    logic [7:0]             mem [32];

    always_comb begin
        state_d = state_q;
        sync_d  = {sync_q[SYNC_STAGES-2:0], ld_strobe};
        edge_d  = sync_q[SYNC_STAGES-1];
        len_d   = len_q;
        cnt_d   = cnt_q;
        wptr_d  = wptr_q;
        csum_d  = csum_q;
        run_d   = run_q;
        err_d   = err_q;
        we      = 1'b0;
        byte_ev = sync_q[SYNC_STAGES-1] & ~edge_q;

        case (state_q)
            S_IDLE: if (ld_en) begin
                state_d = S_HDR;
                run_d   = 1'b0;
                err_d   = 1'b0;
            end
            S_DONE, S_ERR: if (!ld_en) state_d = S_IDLE;
            default: begin
                // Dropping ld_en mid-frame wins over any byte arriving in the same cycle.
                if (!ld_en) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                    run_d   = 1'b0;
                end else if (byte_ev) begin
                    case (state_q)
                        S_HDR: if (ld_data == HDR_BYTE) state_d = S_LEN;
                        S_LEN: begin
                            if (ld_data >= 8'd1 && ld_data <= 8'd32) begin
                                state_d = S_DATA;
                                len_d   = ld_data[5:0];
                                cnt_d   = 6'd0;
                                wptr_d  = 5'd0;
                                csum_d  = 8'h00;
                            end else begin
                                state_d = S_ERR;
                                err_d   = 1'b1;
                            end
                        end
                        S_DATA: begin
                            we     = 1'b1;
                            wptr_d = wptr_q + 5'd1;
                            cnt_d  = cnt_q + 6'd1;
                            csum_d = csum_q ^ ld_data;
                            if (cnt_q + 6'd1 == len_q) state_d = S_CHK;
                        end
                        S_CHK: begin
                            if (ld_data == csum_q) begin
                                state_d = S_DONE;
                                run_d   = 1'b1;
                            end else begin
                                state_d = S_ERR;
                                err_d   = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase

        busy_d = (state_d == S_HDR) || (state_d == S_LEN) ||
                 (state_d == S_DATA) || (state_d == S_CHK);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            sync_q  <= '0;
            edge_q  <= 1'b0;
            len_q   <= 6'd0;
            cnt_q   <= 6'd0;
            wptr_q  <= 5'd0;
            csum_q  <= 8'h00;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            edge_q  <= edge_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            csum_q  <= csum_d;
            run_q   <= run_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Store contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) mem[wptr_q] <= ld_data;
    end

    assign fetch_data = run_q ? mem[fetch_addr] : 8'h00;
    assign cpu_run    = run_q;
    assign ld_busy    = busy_q;
    assign ld_err     = err_q;
    assign ld_count   = cnt_q;

endmodule

// File: tb/tb_tiny_cpu_prog_loader.sv
// Scoreboard bench: expected frame outcome queued when a frame is sent, checked when the frame ends.
module tb_tiny_cpu_prog_loader;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ld_en = 1'b0;
    logic       ld_strobe = 1'b0;
    logic [7:0] ld_data = 8'h00;
    logic [4:0] fetch_addr = 5'd0;
    logic [7:0] fetch_data;
    logic       cpu_run, ld_busy, ld_err;
    logic [5:0] ld_count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       run;
        logic       err;
        logic [5:0] cnt;
        bit         cnt_chk;
    } exp_t;
    exp_t sb[$];

    tiny_cpu_prog_loader #(.HDR_BYTE(8'hA5), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .ld_en(ld_en), .ld_strobe(ld_strobe),
        .ld_data(ld_data), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
        .cpu_run(cpu_run), .ld_busy(ld_busy), .ld_err(ld_err), .ld_count(ld_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        ld_data = b;
        @(negedge clk);
        ld_strobe = 1'b1;
        repeat (hold) @(negedge clk);
        ld_strobe = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i], 4);
    endtask

    task automatic start_frame();
        ld_en = 1'b1;
        @(negedge clk);
    endtask

    // Wait (bounded) for the frame to leave the busy states, then compare against the queued outcome.
    task automatic finish_frame(input string tag);
        exp_t e;
        int n = 0;
        while (ld_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk({tag, "_timeout"}, 1, 0);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_run"}, cpu_run, e.run);
            chk({tag, "_err"}, ld_err, e.err);
            if (e.cnt_chk) chk({tag, "_cnt"}, ld_count, e.cnt);
        end
    endtask

    task automatic end_frame();
        ld_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic fetch_chk(input string tag, input logic [4:0] a, input logic [7:0] exp);
        fetch_addr = a;
        #1;
        chk(tag, fetch_data, exp);
    endtask

    initial begin
        logic [7:0] fr[$];
        logic [7:0] big[32];
        logic [7:0] x;

        repeat (3) @(negedge clk);
        chk("rst_run", cpu_run, 0);
        chk("rst_busy", ld_busy, 0);
        chk("rst_err", ld_err, 0);
        chk("rst_cnt", ld_count, 0);
        chk("rst_fetch", fetch_data, 8'h00);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", ld_busy, 0);

        // Good frame
        start_frame();
        chk("good_busy", ld_busy, 1);
        fr = '{8'hA5, 8'h03, 8'h21, 8'h7D, 8'hA3, 8'hFF};
        sb.push_back('{1'b1, 1'b0, 6'd3, 1'b1});
        send_frame(fr);
        finish_frame("good");
        fetch_chk("good_m0", 5'd0, 8'h21);
        fetch_chk("good_m1", 5'd1, 8'h7D);
        fetch_chk("good_m2", 5'd2, 8'hA3);
        end_frame();
        chk("done_idle_run", cpu_run, 1);

        // Bad checksum
        start_frame();
        chk("new_frame_run_clr", cpu_run, 0);
        fr = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h00};
        sb.push_back('{1'b0, 1'b1, 6'd2, 1'b1});
        send_frame(fr);
        finish_frame("badsum");
        for (int a = 0; a < 32; a += 7) fetch_chk("badsum_nop", a[4:0], 8'h00);
        end_frame();
        chk("err_sticky_idle", ld_err, 1);

        // Length bounds
        start_frame();
        chk("err_clr_on_start", ld_err, 0);
        fr = '{8'hA5, 8'h00};
        sb.push_back('{1'b0, 1'b1, 6'd0, 1'b0});
        send_frame(fr);
        finish_frame("len0");
        end_frame();

        start_frame();
        fr = '{8'hA5, 8'h21};
        sb.push_back('{1'b0, 1'b1, 6'd0, 1'b0});
        send_frame(fr);
        finish_frame("len33");
        end_frame();

        start_frame();
        x = 8'h00;
        fr = '{8'hA5, 8'h20};
        for (int i = 0; i < 32; i++) begin
            big[i] = 8'($urandom_range(0, 255));
            x ^= big[i];
            fr.push_back(big[i]);
        end
        fr.push_back(x);
        sb.push_back('{1'b1, 1'b0, 6'd32, 1'b1});
        send_frame(fr);
        finish_frame("len32");
        fetch_chk("len32_m0", 5'd0, big[0]);
        fetch_chk("len32_m31", 5'd31, big[31]);
        fetch_chk("len32_m15", 5'd15, big[15]);
        end_frame();

        // Header hunt
        start_frame();
        fr = '{8'h00, 8'h5A, 8'hA5, 8'h01, 8'h3C, 8'h3C};
        sb.push_back('{1'b1, 1'b0, 6'd1, 1'b1});
        send_frame(fr);
        finish_frame("hunt");
        fetch_chk("hunt_m0", 5'd0, 8'h3C);
        end_frame();

        // Abort after 2 of 4 data bytes
        start_frame();
        fr = '{8'hA5, 8'h04, 8'h01, 8'h02};
        send_frame(fr);
        chk("abort_busy_pre", ld_busy, 1);
        ld_en = 1'b0;
        @(negedge clk);
        chk("abort_busy", ld_busy, 0);
        sb.push_back('{1'b0, 1'b1, 6'd2, 1'b1});
        finish_frame("abort");
        end_frame();
        start_frame();
        chk("abort_err_clr", ld_err, 0);
        fr = '{8'hA5, 8'h02, 8'h12};
        sb.push_back('{1'b1, 1'b0, 6'd2, 1'b1});
        send_frame(fr);
        send_byte(8'h34, 10);   // long strobe: exactly one byte event
        chk("long_strobe_cnt", ld_count, 2);
        send_byte(8'h26, 4);
        finish_frame("regood");
        fetch_chk("regood_m1", 5'd1, 8'h34);
        end_frame();

        // Reset pulse mid-DATA
        start_frame();
        fr = '{8'hA5, 8'h03, 8'h55};
        send_frame(fr);
        chk("pre_rst_cnt", ld_count, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", ld_busy, 0);
        chk("mid_rst_cnt", ld_count, 0);
        chk("mid_rst_run", cpu_run, 0);
        chk("mid_rst_err", ld_err, 0);
        ld_en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", ld_busy, 0);
        start_frame();
        fr = '{8'hA5, 8'h01, 8'h77, 8'h77};
        sb.push_back('{1'b1, 1'b0, 6'd1, 1'b1});
        send_frame(fr);
        finish_frame("post_rst");
        fetch_chk("post_rst_m0", 5'd0, 8'h77);
        fetch_chk("post_rst_keep_m1", 5'd1, 8'h34);
        end_frame();

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
